pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline control unit for the five-stage RISC-V core; it produces the `stall[5:0]` vector and `ex_b_flag` flush that every inter-stage register (IF_ID, ID_EX, EX_MEM, MEM_WB) and the PC register consume. It arbitrates level stall requests from IF, ID and MEM. It accepts taken branches and jumps from EX, and holds a branch redirect pending while an instruction fetch is still outstanding. It also keeps a saturating stall-cycle counter for performance debug.

## Interface
Parameters:
- `CNT_W`, default 32: width of the stall-cycle counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `if_stall_req`  in  1  the IF fetch is outstanding (level).
- `id_stall_req`  in  1  ID has detected a load-use hazard (level).
- `mem_stall_req`  in  1  the MEM data access is outstanding (level).
- `ex_b_req`  in  1  the instruction in EX is a taken branch or jump (level while it sits in EX).
- `ex_b_target`  in  `InstAddrBus`  the redirect target from EX.
- `stall`  out  6  stall vector: bit 0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB.
- `ex_b_flag`  out  1  one-cycle flush of IF_ID and ID_EX.
- `pc_redirect`  out  1  the PC loads `pc_redirect_addr` this edge.
- `pc_redirect_addr`  out  `InstAddrBus`  the redirect address.
- `if_flush`  out  1  discard the fetch result returned this cycle.
- `stall_cycles`  out  `CNT_W`  saturating count of stalled cycles.

## Operation
- **Stall vector.** `stall` is combinational. Priority is MEM, then ID, then IF.
  - `mem_stall_req` gives `6'b011111`.
  - Otherwise `id_stall_req` gives `6'b000111`.
  - Otherwise `if_stall_req` gives `6'b000011`.
  - Otherwise, or in REDIR_WAIT state, the IF pattern `6'b000011` applies; with no request in RUN the vector is `6'b000000`.
- **Monotonic rule.** If `stall[k]` is 1, then every `stall[j]` with j < k is 1. Downstream bubble insertion relies on this (a stage is stalled while the next stage is not).
- **Branch acceptance.** A branch is accepted only when `ex_b_req=1`, `stall[3]=0`, and the state is RUN. A branch sitting in a stalled EX is re-presented later and is not accepted early.
- **On acceptance:**
  - `ex_b_flag=1` for exactly that cycle.
  - If `if_stall_req=0`: `pc_redirect=1` in the same cycle, `pc_redirect_addr=ex_b_target`, and the state stays RUN.
  - If `if_stall_req=1`: the target is latched into `pend_addr` and the state goes to REDIR_WAIT.
- **REDIR_WAIT.**
  - `ex_b_flag=0`, and IF and PC are held stalled.
  - In the first cycle with `if_stall_req=0`: `pc_redirect=1`, `pc_redirect_addr=pend_addr`, `if_flush=1`, then the state returns to RUN.
  - A MEM stall during REDIR_WAIT takes the `6'b011111` pattern but does not clear the pending redirect.
  - An `ex_b_req` during REDIR_WAIT is ignored, because ID and EX already hold bubbles.
- **Counter.** `stall_cycles` increments in every cycle with `stall[0]=1`. It saturates at all-ones.
- **Reset.**
  - While `rst=1`, all outputs are forced to 0.
  - The state goes to RUN, `pend_addr` to 0, and `stall_cycles` to 0.
  - Reset asserted mid-REDIR_WAIT drops the pending redirect.

## Timing
- Request inputs to `stall`: 0-cycle latency, combinational.
- `ex_b_req` to `ex_b_flag` / `pc_redirect`: 0 cycles when accepted in RUN with IF idle. The flushed registers and the PC update on the next rising edge.
- Deferred redirect: the redirect happens in the first cycle `if_stall_req` falls. Minimum 1 cycle after acceptance, unbounded otherwise.
- `stall_cycles`: registered; it reflects a stalled cycle one edge later.
- A simultaneous MEM stall and taken branch gives `stall=6'b011111` with no flush, because EX is stalled.
- A simultaneous ID stall and taken branch gives `stall[3]=0`, so the branch is accepted. The flush overrides the ID_EX bubble, and the net content is a NOP either way.

## Structure
- Put in `Defines.vh`:
  - `StallBus` (5:0).
  - The patterns `STALL_NONE`, `STALL_IF`, `STALL_ID`, `STALL_MEM`.
  - The state encodings `CTRL_RUN` and `CTRL_REDIR_WAIT`.
- `InstAddrBus` comes from the existing defines.
- Sub-module: `sat_counter` (parameter width, an increment enable, saturation), instantiated for `stall_cycles`.
- Everything else (priority encoder, two-state FSM, `pend_addr` register) lives in `pipe_ctrl`.

## Test plan
- **Reset mid-wait.** Assert `rst` asynchronously in the middle of REDIR_WAIT, then release → all outputs are 0 during reset and `stall_cycles=0`. After release the state is RUN with no redirect.
- **Stall patterns and priority.**
  - `id_stall_req=1` alone → `stall=6'b000111`.
  - `mem_stall_req=1` with `id_stall_req=1` → `6'b011111`.
  - `if_stall_req=1` alone → `6'b000011`.
- **Immediate redirect.** `ex_b_req=1`, `ex_b_target=32'h0000_0100`, all requests idle → in the same cycle `ex_b_flag=1`, `pc_redirect=1` and `pc_redirect_addr=32'h100`. The next cycle both are 0.
- **Deferred redirect.** Branch accepted to `32'h200` with `if_stall_req=1` held 3 cycles → `ex_b_flag` pulses 1 cycle and `stall[1:0]=2'b11` throughout. In the cycle `if_stall_req` drops: `pc_redirect=1`, `addr=32'h200`, `if_flush=1`.
- **Branch under MEM stall.** `ex_b_req=1` with `mem_stall_req=1` for 2 cycles → no flush during those cycles. Flush and redirect occur in the cycle the MEM stall clears.
- **Counter saturation.** `CNT_W=4`, `if_stall_req` held 20 cycles → `stall_cycles` counts 1..15, then holds at `4'hF`.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: instruction address bus, stall bus, stall patterns, controller states.
package pipe_ctrl_pkg;

  typedef logic [31:0] inst_addr_t;
  typedef logic [5:0]  stall_t;

  // Stall vector bit order: 0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB.
  // Every pattern is a contiguous run of ones starting at bit 0.
  localparam stall_t STALL_NONE = 6'b000000;
  localparam stall_t STALL_IF   = 6'b000011;
  localparam stall_t STALL_ID   = 6'b000111;
  localparam stall_t STALL_MEM  = 6'b011111;

  typedef enum logic {
    CTRL_RUN        = 1'b0,
    CTRL_REDIR_WAIT = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter: increments on inc and holds at all-ones.
// Latency: 1 cycle (registered count).
// Backpressure: none; inc is sampled every cycle.
// Ports: clk, rst (async high), inc (enable), cnt (count value).
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall priority encoder, branch redirect FSM, stall-cycle counter.
// Latency: stall/flush/redirect combinational; deferred redirect waits for IF idle; counter +1 edge.
// Backpressure: a branch in a stalled EX is not accepted; the redirect is held while a fetch is outstanding.
// Ports: clk, rst; if/id/mem stall requests; ex_b_req/ex_b_target from EX;
//        stall vector, ex_b_flag, pc_redirect(+addr), if_flush, stall_cycles.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_stall_req,
  input  logic             id_stall_req,
  input  logic             mem_stall_req,
  input  logic             ex_b_req,
  input  inst_addr_t       ex_b_target,
  output stall_t           stall,
  output logic             ex_b_flag,
  output logic             pc_redirect,
  output inst_addr_t       pc_redirect_addr,
  output logic             if_flush,
  output logic [CNT_W-1:0] stall_cycles
);

  ctrl_state_t state, state_nxt;
  inst_addr_t  pend_addr;
  logic        pend_load;

  stall_t     stall_req;
  stall_t     stall_raw;
  logic       flag_raw;
  logic       redir_raw;
  inst_addr_t redir_addr_raw;
  logic       flush_raw;

  // Priority encoder; all patterns are monotonic so OR-ing them keeps that property.
  always_comb begin
    if (mem_stall_req)     stall_req = STALL_MEM;
    else if (id_stall_req) stall_req = STALL_ID;
    else if (if_stall_req) stall_req = STALL_IF;
    else                   stall_req = STALL_NONE;
  end

  // While a redirect is pending, PC and IF stay frozen on top of any other request.
  assign stall_raw = stall_req | ((state == CTRL_REDIR_WAIT) ? STALL_IF : STALL_NONE);

  always_comb begin
    state_nxt      = state;
    pend_load      = 1'b0;
    flag_raw       = 1'b0;
    redir_raw      = 1'b0;
    redir_addr_raw = '0;
    flush_raw      = 1'b0;
    case (state)
      CTRL_RUN: begin
        if (ex_b_req && !stall_raw[3]) begin
          flag_raw = 1'b1;
          if (!if_stall_req) begin
            redir_raw      = 1'b1;
            redir_addr_raw = ex_b_target;
          end else begin
            pend_load = 1'b1;
            state_nxt = CTRL_REDIR_WAIT;
          end
        end
      end
      CTRL_REDIR_WAIT: begin
        // ex_b_req is ignored here: ID and EX already hold flushed bubbles.
        if (!if_stall_req) begin
          redir_raw      = 1'b1;
          redir_addr_raw = pend_addr;
          flush_raw      = 1'b1;
          state_nxt      = CTRL_RUN;
        end
      end
      default: state_nxt = CTRL_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CTRL_RUN;
      pend_addr <= '0;
    end else begin
      state <= state_nxt;
      if (pend_load) pend_addr <= ex_b_target;
    end
  end

  // Outputs are forced low for as long as reset is held.
  assign stall            = rst ? STALL_NONE : stall_raw;
  assign ex_b_flag        = !rst && flag_raw;
  assign pc_redirect      = !rst && redir_raw;
  assign pc_redirect_addr = rst ? '0 : redir_addr_raw;
  assign if_flush         = !rst && flush_raw;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall[0]),
    .cnt (stall_cycles)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall priority, immediate/deferred redirect,
// branch under MEM stall, async reset mid-wait, 4-bit counter saturation.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       if_stall_req, id_stall_req, mem_stall_req, ex_b_req;
  inst_addr_t ex_b_target;

  stall_t     stall, stall4;
  logic       ex_b_flag, pc_redirect, if_flush;
  logic       ex_b_flag4, pc_redirect4, if_flush4;
  inst_addr_t pc_redirect_addr, pc_redirect_addr4;
  logic [31:0] stall_cycles;
  logic [3:0]  stall_cycles4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_W(32)) u_dut (
    .clk(clk), .rst(rst),
    .if_stall_req(if_stall_req), .id_stall_req(id_stall_req),
    .mem_stall_req(mem_stall_req), .ex_b_req(ex_b_req), .ex_b_target(ex_b_target),
    .stall(stall), .ex_b_flag(ex_b_flag), .pc_redirect(pc_redirect),
    .pc_redirect_addr(pc_redirect_addr), .if_flush(if_flush),
    .stall_cycles(stall_cycles)
  );

  pipe_ctrl #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .if_stall_req(if_stall_req), .id_stall_req(id_stall_req),
    .mem_stall_req(mem_stall_req), .ex_b_req(ex_b_req), .ex_b_target(ex_b_target),
    .stall(stall4), .ex_b_flag(ex_b_flag4), .pc_redirect(pc_redirect4),
    .pc_redirect_addr(pc_redirect_addr4), .if_flush(if_flush4),
    .stall_cycles(stall_cycles4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic i, input logic d, input logic m, input logic b,
                       input inst_addr_t t);
    if_stall_req  = i;
    id_stall_req  = d;
    mem_stall_req = m;
    ex_b_req      = b;
    ex_b_target   = t;
    #2;
  endtask

  task automatic chk_out(input string tag, input stall_t s, input logic f,
                         input logic r, input inst_addr_t a, input logic fl);
    chk({tag, ".stall"}, 64'(stall), 64'(s));
    chk({tag, ".flag"},  64'(ex_b_flag), 64'(f));
    chk({tag, ".redir"}, 64'(pc_redirect), 64'(r));
    chk({tag, ".addr"},  64'(pc_redirect_addr), 64'(a));
    chk({tag, ".flush"}, 64'(if_flush), 64'(fl));
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    // Outputs must be zero during reset even with requests raised.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0abc);
    chk_out("rst", 6'b000000, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("rst.cnt", 64'(stall_cycles), 64'd0);
    step();
    step();
    rst = 1'b0;

    // Stall patterns and priority.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("pri.id", 64'(stall), 64'(6'b000111));
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("pri.mem_id", 64'(stall), 64'(6'b011111));
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("pri.if", 64'(stall), 64'(6'b000011));
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("pri.none", 64'(stall), 64'(6'b000000));
    step();

    // Immediate redirect.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
    chk_out("imm", 6'b000000, 1'b1, 1'b1, 32'h0000_0100, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0100);
    chk_out("imm.next", 6'b000000, 1'b0, 1'b0, 32'h0, 1'b0);
    step();

    // Deferred redirect: accepted with fetch outstanding, IF busy 3 cycles.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0200);
    chk_out("def.acc", 6'b000011, 1'b1, 1'b0, 32'h0, 1'b0);
    step();
    // A new branch request while waiting must be ignored.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0bad);
    chk_out("def.w1", 6'b000011, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_out("def.w2", 6'b000011, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("def.stall10", 64'(stall[1:0]), 64'(2'b11));
    chk("def.redir", 64'(pc_redirect), 64'd1);
    chk("def.addr", 64'(pc_redirect_addr), 64'h200);
    chk("def.flush", 64'(if_flush), 64'd1);
    chk("def.flag", 64'(ex_b_flag), 64'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_out("def.after", 6'b000000, 1'b0, 1'b0, 32'h0, 1'b0);
    step();

    // Branch sitting in EX under a MEM stall.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0300);
    chk_out("mem.c1", 6'b011111, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0300);
    chk_out("mem.c2", 6'b011111, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0300);
    chk_out("mem.clr", 6'b000000, 1'b1, 1'b1, 32'h0000_0300, 1'b0);
    step();

    // ID stall with branch: EX not stalled, so accepted.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0340);
    chk_out("id_br", 6'b000111, 1'b1, 1'b1, 32'h0000_0340, 1'b0);
    step();

    // Reset asserted asynchronously in the middle of REDIR_WAIT.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0400);
    chk("rw.acc", 64'(ex_b_flag), 64'd1);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    #1;
    chk_out("rw.rst", 6'b000000, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("rw.cnt", 64'(stall_cycles), 64'd0);
    chk("rw.cnt4", 64'(stall_cycles4), 64'd0);
    step();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_out("rw.rel", 6'b000000, 1'b0, 1'b0, 32'h0, 1'b0);
    step();

    // Counter: 20 stalled cycles; 4-bit instance saturates at 15.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 1; i <= 20; i++) begin
      step();
      chk($sformatf("sat.%0d", i), 64'(stall_cycles4), 64'((i > 15) ? 15 : i));
    end
    chk("cnt32", 64'(stall_cycles), 64'd20);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    chk("cnt32.hold", 64'(stall_cycles), 64'd20);
    chk("cnt4.hold", 64'(stall_cycles4), 64'hF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
